gshare_branch_pred: RTL and testbench
=====================================

GSHARE_BRANCH_PRED -- requirements
Module: gshare_branch_pred

Interface
REQ-001 SHALL have parameter GHR_BITS, default 2: global history length m (>=1).
REQ-002 SHALL have parameter PC_BITS, default 4: PC index bits taken from PC[PC_BITS+1:2].
REQ-003 SHALL have parameter CNT_BITS, default 2: saturating counter width n (>=1).
REQ-004 SHALL have parameter HASH_MODE, default 0: 0 = concat {ghr,pcbits}; 1 = xor (requires GHR_BITS<=PC_BITS).
REQ-005 SHALL have parameter INIT_CNT, default all-ones: counter init value (predict taken).
REQ-006 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port pred_req  input  1  lookup request this cycle.
REQ-009 SHALL have port pred_pc  input  32  PC of the branch being looked up.
REQ-010 SHALL have ports pred_valid / pred_taken  output  1 / 1  registered lookup result.
REQ-011 SHALL have port pred_ghr  output  GHR_BITS  history used for the lookup; the pipeline carries it to update.
REQ-012 SHALL have ports upd_valid / upd_taken / upd_pred  input  1 each  resolve strobe, actual outcome, prediction made.
REQ-013 SHALL have ports upd_pc / upd_ghr  input  32 / GHR_BITS  PC and checkpointed history of the resolving branch.
REQ-014 SHALL have port ready  output  1  table initialised, accepting traffic.
REQ-015 SHALL have ports stat_lookups / stat_mispred  output  32 each  lookup and mispredict counts, wrap modulo 2^32.

Function
REQ-016 Index width IDX_W SHALL be GHR_BITS+PC_BITS (mode 0) or PC_BITS (mode 1, ghr zero-extended, then xor); PHT depth is 2^IDX_W.
REQ-017 FSM SHALL have states INIT and READY; INIT writes INIT_CNT to one entry per cycle, index 0 upward.
REQ-018 INIT->READY SHALL occur after exactly 2^IDX_W write cycles; ready=1 from the next cycle onward.
REQ-019 In INIT, pred_req and upd_valid SHALL be ignored: no output, GHR, stat or table change.
REQ-020 In READY, pred_req at edge N SHALL give pred_valid=1 for one cycle after edge N, with pred_taken = counter MSB.
REQ-021 pred_ghr SHALL equal the GHR value before the shift. At the same edge, GHR SHALL become {GHR[m-2:0],pred_taken}, and stat_lookups SHALL increment.
REQ-022 Update in READY SHALL index with upd_pc/upd_ghr. The counter SHALL increment if taken and decrement if not, saturating at 2^n-1 and at 0.
REQ-023 Mispredict (upd_pred != upd_taken) SHALL set GHR to {upd_ghr[m-2:0],upd_taken} (m=1: upd_taken) and increment stat_mispred.
REQ-024 On a mispredict update, repair SHALL override a same-cycle speculative shift, and that cycle's pred_req SHALL yield pred_valid=0 and no stat_lookups increment.
REQ-025 When a lookup and an update hit the same index in one cycle, the lookup SHALL return the pre-update counter value.
REQ-026 A correctly predicted update SHALL leave GHR unchanged.

Reset
REQ-027 rst SHALL immediately set FSM to INIT and sweep index to 0. It SHALL also clear GHR, pred_valid, pred_taken, pred_ghr, ready, stat_lookups and stat_mispred to 0.
REQ-028 rst asserted mid-sweep or mid-operation SHALL restart the full sweep after deassertion, and no partial table state SHALL be observable.

Structure
REQ-029 Package corr_bp_pkg SHALL hold the HASH_CONCAT/HASH_XOR constants, the FSM state encoding and the IDX_W derivation function.
REQ-030 The counter table, init sweep and saturating update SHALL be sub-module bp_pht (async read, sync write). Top SHALL hold GHR, output registers and statistics.

Verification (defaults: concat, IDX_W=6, 64 entries, init 2'b11)
REQ-031 Release rst, hold pred_req=1 -> ready rises exactly 64 cycles later, with no pred_valid before; first pred pc=0x10 -> pred_taken=1, pred_ghr=00, GHR becomes 01.
REQ-032 Four updates pc=0x10, ghr=00, taken=0 -> counter 11,10,01,00,00; lookup pc=0x10 with GHR=00 -> pred_taken=0.
REQ-033 GHR=11; upd ghr=01, taken=0, pred=1 with same-cycle pred_req -> GHR=10, pred_valid=0 next cycle, stat_mispred=1.
REQ-034 Same-cycle lookup and update to entry at counter 01 with taken=1 -> pred_taken=0, then the next lookup gives 1.
REQ-035 rst asserted at sweep cycle 30 -> ready=0, stats=0; after release, ready rises 64 cycles later.
REQ-036 HASH_MODE=1, GHR_BITS=4, PC_BITS=4: upd pc=0x3C, ghr=1010, taken=0 -> only entry 0101 changes (11->10).

Source files
------------

// File: rtl/corr_bp_pkg.sv
// Shared definitions for the gshare branch predictor: hash mode selectors,
// FSM state encoding and the table index width derivation.
package corr_bp_pkg;

  localparam int HASH_CONCAT = 0;
  localparam int HASH_XOR    = 1;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } bp_state_e;

  // Concat mode appends the history above the PC bits; xor mode folds the
  // (zero-extended) history into the PC bits, so the index stays PC-sized.
  function automatic int calc_idx_w(input int ghr_bits, input int pc_bits,
                                    input int hash_mode);
    return (hash_mode == HASH_XOR) ? pc_bits : ghr_bits + pc_bits;
  endfunction

endpackage

// File: rtl/gshare_branch_pred_if.sv
// Bundle of the lookup, resolve and status signals of the gshare predictor.
// The master side issues lookups/updates; the slave side is the predictor.
interface gshare_branch_pred_if #(
  parameter int GHR_BITS = 2
);

  logic                pred_req;
  logic [31:0]         pred_pc;
  logic                pred_valid;
  logic                pred_taken;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                upd_valid;
  logic                upd_taken;
  logic                upd_pred;
  logic [31:0]         upd_pc;
  logic [GHR_BITS-1:0] upd_ghr;
  logic                ready;
  logic [31:0]         stat_lookups;
  logic [31:0]         stat_mispred;

  modport master (
    output pred_req, pred_pc, upd_valid, upd_taken, upd_pred, upd_pc, upd_ghr,
    input  pred_valid, pred_taken, pred_ghr, ready, stat_lookups, stat_mispred
  );

  modport slave (
    input  pred_req, pred_pc, upd_valid, upd_taken, upd_pred, upd_pc, upd_ghr,
    output pred_valid, pred_taken, pred_ghr, ready, stat_lookups, stat_mispred
  );

endinterface

// File: rtl/bp_pht.sv
// Pattern history table: 2^IDX_W saturating counters with an asynchronous
// read port and one synchronous update port. After reset it sweeps every
// entry to INIT_CNT, one per cycle, before reporting ready.
module bp_pht
  import corr_bp_pkg::*;
#(
  parameter int                  IDX_W    = 6,
  parameter int                  CNT_BITS = 2,
  parameter logic [CNT_BITS-1:0] INIT_CNT = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken,
  output logic             ready
);

  localparam int                  DEPTH    = 1 << IDX_W;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

  bp_state_e           state_q, state_d;
  logic [IDX_W-1:0]    sweep_q, sweep_d;
  logic [CNT_BITS-1:0] pht_mem [DEPTH];

  function automatic logic [CNT_BITS-1:0] sat_step(input logic [CNT_BITS-1:0] cnt,
                                                   input logic taken);
    if (taken) return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    return (cnt == '0) ? cnt : cnt - 1'b1;
  endfunction

  // State and sweep pointer; reset restarts the full initialisation sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Advance the sweep one entry per cycle; leave INIT after the last entry.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == ST_INIT) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == LAST_IDX) state_d = ST_READY;
    end
  end

  // Table writes: init value during the sweep, saturating step afterwards.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      pht_mem[sweep_q] <= INIT_CNT;
    end else if (wr_en) begin
      pht_mem[wr_idx] <= sat_step(pht_mem[wr_idx], wr_taken);
    end
  end

  // The read sees the table before this cycle's update lands.
  assign rd_taken = pht_mem[rd_idx][CNT_BITS-1];
  assign ready    = (state_q == ST_READY);

endmodule

// File: rtl/gshare_branch_pred.sv
// Gshare branch predictor top: hashes PC and global history into the PHT,
// registers the prediction, speculatively shifts the history on lookups,
// repairs it on mispredicts and keeps lookup/mispredict statistics.
module gshare_branch_pred
  import corr_bp_pkg::*;
#(
  parameter int                  GHR_BITS  = 2,
  parameter int                  PC_BITS   = 4,
  parameter int                  CNT_BITS  = 2,
  parameter int                  HASH_MODE = HASH_CONCAT,
  parameter logic [CNT_BITS-1:0] INIT_CNT  = '1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_req,
  input  logic [31:0]         pred_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic                upd_taken,
  input  logic                upd_pred,
  input  logic [31:0]         upd_pc,
  input  logic [GHR_BITS-1:0] upd_ghr,
  output logic                ready,
  output logic [31:0]         stat_lookups,
  output logic [31:0]         stat_mispred
);

  localparam int IDX_W = calc_idx_w(GHR_BITS, PC_BITS, HASH_MODE);

  logic [GHR_BITS-1:0] ghr_q;
  logic [IDX_W-1:0]    rd_idx;
  logic [IDX_W-1:0]    wr_idx;
  logic                rd_taken;
  logic                do_update;
  logic                do_repair;
  logic                do_lookup;
  logic                unused_pc_bits;

  function automatic logic [IDX_W-1:0] hash_idx(input logic [PC_BITS-1:0]  pcb,
                                                input logic [GHR_BITS-1:0] h);
    if (HASH_MODE == HASH_XOR) return IDX_W'(pcb ^ PC_BITS'(h));
    return IDX_W'({h, pcb});
  endfunction

  // Shift a new outcome into the low end of a history value.
  function automatic logic [GHR_BITS-1:0] shift_in(input logic [GHR_BITS-1:0] h,
                                                   input logic b);
    return GHR_BITS'({h, b});
  endfunction

  assign rd_idx = hash_idx(pred_pc[PC_BITS+1:2], ghr_q);
  assign wr_idx = hash_idx(upd_pc[PC_BITS+1:2], upd_ghr);

  // Only word-aligned PC index bits take part in the hash.
  assign unused_pc_bits = ^{pred_pc[31:PC_BITS+2], pred_pc[1:0],
                            upd_pc[31:PC_BITS+2], upd_pc[1:0]};

  // A mispredict repair squashes any lookup in the same cycle, since the
  // history that lookup would use is already known to be wrong.
  assign do_update = upd_valid & ready;
  assign do_repair = do_update & (upd_pred != upd_taken);
  assign do_lookup = pred_req & ready & ~do_repair;

  bp_pht #(
    .IDX_W    (IDX_W),
    .CNT_BITS (CNT_BITS),
    .INIT_CNT (INIT_CNT)
  ) u_pht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (rd_idx),
    .rd_taken (rd_taken),
    .wr_en    (do_update),
    .wr_idx   (wr_idx),
    .wr_taken (upd_taken),
    .ready    (ready)
  );

  // Prediction outputs, global history and statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q        <= '0;
      pred_valid   <= 1'b0;
      pred_taken   <= 1'b0;
      pred_ghr     <= '0;
      stat_lookups <= '0;
      stat_mispred <= '0;
    end else begin
      pred_valid <= do_lookup;
      if (do_lookup) begin
        pred_taken   <= rd_taken;
        pred_ghr     <= ghr_q;
        stat_lookups <= stat_lookups + 32'd1;
      end
      if (do_repair) begin
        ghr_q        <= shift_in(upd_ghr, upd_taken);
        stat_mispred <= stat_mispred + 32'd1;
      end else if (do_lookup) begin
        ghr_q <= shift_in(ghr_q, rd_taken);
      end
    end
  end

endmodule

// File: tb/tb_gshare_branch_pred.sv
// Bench for gshare_branch_pred: default-parameter instance checked every
// cycle against a table-level model plus literal expectations, and an xor
// hash instance checked with literal expectations.
module tb_gshare_branch_pred;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  gshare_branch_pred_if #(.GHR_BITS(2)) bif ();
  gshare_branch_pred_if #(.GHR_BITS(4)) xif ();

  gshare_branch_pred dut (
    .clk(clk), .rst(rst),
    .pred_req(bif.pred_req), .pred_pc(bif.pred_pc),
    .pred_valid(bif.pred_valid), .pred_taken(bif.pred_taken), .pred_ghr(bif.pred_ghr),
    .upd_valid(bif.upd_valid), .upd_taken(bif.upd_taken), .upd_pred(bif.upd_pred),
    .upd_pc(bif.upd_pc), .upd_ghr(bif.upd_ghr),
    .ready(bif.ready), .stat_lookups(bif.stat_lookups), .stat_mispred(bif.stat_mispred)
  );

  gshare_branch_pred #(.GHR_BITS(4), .PC_BITS(4), .HASH_MODE(1)) dut_x (
    .clk(clk), .rst(rst),
    .pred_req(xif.pred_req), .pred_pc(xif.pred_pc),
    .pred_valid(xif.pred_valid), .pred_taken(xif.pred_taken), .pred_ghr(xif.pred_ghr),
    .upd_valid(xif.upd_valid), .upd_taken(xif.upd_taken), .upd_pred(xif.upd_pred),
    .upd_pc(xif.upd_pc), .upd_ghr(xif.upd_ghr),
    .ready(xif.ready), .stat_lookups(xif.stat_lookups), .stat_mispred(xif.stat_mispred)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the default instance ----------------
  int m_cnt [64];
  int m_ghr, m_init, m_lk, m_mp, m_pg, m_c, m_ui;
  bit m_ready, m_pv, m_pt, m_mis, m_look;

  function automatic int midx(input logic [31:0] pc, input int g);
    return (g % 4) * 16 + int'(pc[5:2]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) m_cnt[i] = 3;
      m_ghr = 0; m_init = 0; m_ready = 0; m_pv = 0; m_pt = 0; m_pg = 0;
      m_lk = 0; m_mp = 0;
    end else if (!m_ready) begin
      m_init++;
      if (m_init == 64) m_ready = 1;
      m_pv = 0;
    end else begin
      m_mis  = bif.upd_valid && (bif.upd_pred != bif.upd_taken);
      m_look = bif.pred_req && !m_mis;
      m_pv   = m_look;
      if (m_look) begin
        m_pt = (m_cnt[midx(bif.pred_pc, m_ghr)] >= 2);
        m_pg = m_ghr;
        m_lk++;
      end
      if (bif.upd_valid) begin
        m_ui = midx(bif.upd_pc, int'(bif.upd_ghr));
        m_c  = m_cnt[m_ui];
        if (bif.upd_taken) m_cnt[m_ui] = (m_c == 3) ? 3 : m_c + 1;
        else               m_cnt[m_ui] = (m_c == 0) ? 0 : m_c - 1;
      end
      if (m_mis) begin
        m_ghr = (int'(bif.upd_ghr) * 2 + int'(bif.upd_taken)) % 4;
        m_mp++;
      end else if (m_look) begin
        m_ghr = (m_ghr * 2 + int'(m_pt)) % 4;
      end
    end
  end

  // Compare the default instance with the model every cycle.
  always @(negedge clk) begin
    chk("ready", longint'(bif.ready), longint'(m_ready));
    chk("pred_valid", longint'(bif.pred_valid), longint'(m_pv));
    if (m_pv) begin
      chk("pred_taken", longint'(bif.pred_taken), longint'(m_pt));
      chk("pred_ghr", longint'(bif.pred_ghr), longint'(m_pg));
    end
    chk("stat_lookups", longint'(bif.stat_lookups), longint'(m_lk));
    chk("stat_mispred", longint'(bif.stat_mispred), longint'(m_mp));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc1(input bit req, input logic [31:0] pc, input bit uv,
                      input logic [31:0] upc, input logic [1:0] ug,
                      input bit ut, input bit up);
    bif.pred_req = req; bif.pred_pc = pc;
    bif.upd_valid = uv; bif.upd_pc = upc; bif.upd_ghr = ug;
    bif.upd_taken = ut; bif.upd_pred = up;
    @(posedge clk); #1;
    bif.pred_req = 1'b0; bif.upd_valid = 1'b0;
  endtask

  task automatic cyc2(input bit req, input logic [31:0] pc, input bit uv,
                      input logic [31:0] upc, input logic [3:0] ug,
                      input bit ut, input bit up);
    xif.pred_req = req; xif.pred_pc = pc;
    xif.upd_valid = uv; xif.upd_pc = upc; xif.upd_ghr = ug;
    xif.upd_taken = ut; xif.upd_pred = up;
    @(posedge clk); #1;
    xif.pred_req = 1'b0; xif.upd_valid = 1'b0;
  endtask

  task automatic wait_ready1(output int n);
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (bif.ready) begin
        n = k;
        break;
      end
    end
  endtask

  int n_lat;

  initial begin
    rst = 1'b1;
    bif.pred_req = 0; bif.pred_pc = 0; bif.upd_valid = 0; bif.upd_taken = 0;
    bif.upd_pred = 0; bif.upd_pc = 0; bif.upd_ghr = 0;
    xif.pred_req = 0; xif.pred_pc = 0; xif.upd_valid = 0; xif.upd_taken = 0;
    xif.upd_pred = 0; xif.upd_pc = 0; xif.upd_ghr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", longint'(bif.ready), 0);
    chk("reset_pred_valid", longint'(bif.pred_valid), 0);
    chk("reset_lookups", longint'(bif.stat_lookups), 0);

    // Sweep latency with pred_req held high, then first prediction.
    bif.pred_req = 1'b1; bif.pred_pc = 32'h10;
    rst = 1'b0;
    wait_ready1(n_lat);
    chk("ready_latency", n_lat, 64);
    @(posedge clk); #1;
    bif.pred_req = 1'b0;
    chk("first_pv", longint'(bif.pred_valid), 1);
    chk("first_taken", longint'(bif.pred_taken), 1);
    chk("first_ghr", longint'(bif.pred_ghr), 0);
    chk("first_lookups", longint'(bif.stat_lookups), 1);

    // History shifted to 01; another taken lookup makes it 11.
    cyc1(1, 32'h10, 0, 0, 0, 0, 0);
    chk("second_ghr", longint'(bif.pred_ghr), 1);
    chk("second_taken", longint'(bif.pred_taken), 1);

    // Mispredict repair with a same-cycle lookup.
    cyc1(1, 32'h10, 1, 32'h30, 2'b01, 0, 1);
    chk("repair_pv", longint'(bif.pred_valid), 0);
    chk("repair_mispred", longint'(bif.stat_mispred), 1);
    chk("repair_lookups", longint'(bif.stat_lookups), 2);
    cyc1(1, 32'h10, 0, 0, 0, 0, 0);
    chk("repair_ghr", longint'(bif.pred_ghr), 2);

    // Drive entry {00,0100} down to zero, then set GHR to 00 by repair.
    repeat (4) cyc1(0, 0, 1, 32'h10, 2'b00, 0, 0);
    cyc1(0, 0, 1, 32'h20, 2'b00, 0, 1);
    chk("mispred_two", longint'(bif.stat_mispred), 2);
    cyc1(1, 32'h10, 0, 0, 0, 0, 0);
    chk("sat_low_taken", longint'(bif.pred_taken), 0);
    chk("sat_low_ghr", longint'(bif.pred_ghr), 0);

    // Same-cycle lookup/update on a counter at 01.
    cyc1(0, 0, 1, 32'h10, 2'b00, 1, 1);
    cyc1(1, 32'h10, 1, 32'h10, 2'b00, 1, 1);
    chk("bypass_old_value", longint'(bif.pred_taken), 0);
    cyc1(1, 32'h10, 0, 0, 0, 0, 0);
    chk("bypass_new_value", longint'(bif.pred_taken), 1);

    // Reset mid-operation, then again mid-sweep with traffic applied.
    rst = 1'b1; #1;
    chk("midop_rst_pv", longint'(bif.pred_valid), 0);
    chk("midop_rst_lookups", longint'(bif.stat_lookups), 0);
    chk("midop_rst_mispred", longint'(bif.stat_mispred), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bif.pred_req = 1; bif.pred_pc = 32'h10;
    bif.upd_valid = 1; bif.upd_pc = 32'h10; bif.upd_ghr = 0;
    bif.upd_taken = 0; bif.upd_pred = 1;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1; #1;
    chk("sweep_rst_ready", longint'(bif.ready), 0);
    chk("sweep_rst_lookups", longint'(bif.stat_lookups), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready1(n_lat);
    chk("ready_latency_again", n_lat, 64);
    bif.pred_req = 0; bif.upd_valid = 0;
    chk("init_ignored_mispred", longint'(bif.stat_mispred), 0);
    chk("init_ignored_lookups", longint'(bif.stat_lookups), 0);
    cyc1(1, 32'h10, 0, 0, 0, 0, 0);
    chk("reinit_taken", longint'(bif.pred_taken), 1);
    chk("reinit_ghr", longint'(bif.pred_ghr), 0);

    // Xor-hash instance: pc 0x3C with ghr 1010 lands on entry 0101 only.
    chk("x_ready", longint'(xif.ready), 1);
    cyc2(0, 0, 1, 32'h3C, 4'b1010, 0, 0);
    cyc2(0, 0, 1, 32'h3C, 4'b1010, 0, 0);
    cyc2(1, 32'h14, 0, 0, 0, 0, 0);
    chk("x_entry5_taken", longint'(xif.pred_taken), 0);
    chk("x_entry5_ghr", longint'(xif.pred_ghr), 0);
    cyc2(1, 32'h3C, 0, 0, 0, 0, 0);
    chk("x_entry15_taken", longint'(xif.pred_taken), 1);
    cyc2(1, 32'h10, 0, 0, 0, 0, 0);
    chk("x_xor_taken", longint'(xif.pred_taken), 0);
    chk("x_xor_ghr", longint'(xif.pred_ghr), 1);
    cyc2(1, 32'h18, 0, 0, 0, 0, 0);
    chk("x_entry4_taken", longint'(xif.pred_taken), 1);
    chk("x_entry4_ghr", longint'(xif.pred_ghr), 2);
    cyc2(0, 0, 1, 32'h3C, 4'b1010, 1, 1);
    cyc2(1, 32'h00, 0, 0, 0, 0, 0);
    chk("x_step_up_taken", longint'(xif.pred_taken), 1);
    chk("x_step_up_ghr", longint'(xif.pred_ghr), 5);
    chk("x_lookups", longint'(xif.stat_lookups), 5);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
